// File: rtl/cfs_tx_ctrl_skid.sv
// Two-entry skid buffer between a FIFO pop port and the TX sink, with a
// saturating handshake counter and a back-pressure stall detector.
module cfs_tx_ctrl_skid #(
  parameter  int ALGN_DATA_WIDTH = 32,
  parameter  int STALL_THRESHOLD = 16,
  parameter  int CNT_WIDTH       = 16,
  localparam int OFFSET_W = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH / 8),
  localparam int SIZE_W   = $clog2(ALGN_DATA_WIDTH / 8) + 1,
  localparam int FIFO_W   = ALGN_DATA_WIDTH + OFFSET_W + SIZE_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pop_valid,
  input  logic [FIFO_W-1:0]          pop_data,
  output logic                       pop_ready,
  output logic                       md_tx_valid,
  output logic [ALGN_DATA_WIDTH-1:0] md_tx_data,
  output logic [OFFSET_W-1:0]        md_tx_offset,
  output logic [SIZE_W-1:0]          md_tx_size,
  input  logic                       md_tx_ready,
  input  logic                       clr_cnt,
  output logic [CNT_WIDTH-1:0]       tx_cnt,
  output logic                       stall,
  output logic                       stall_pulse
);

  localparam int STALL_W = $clog2(STALL_THRESHOLD + 1);
  localparam logic [STALL_W-1:0]   STALL_MAX = STALL_W'(STALL_THRESHOLD);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t              state, state_nxt;
  logic [FIFO_W-1:0]   head_q, skid_q, head_nxt, skid_nxt;
  logic [STALL_W-1:0]  stall_cnt;
  logic                stall_q;
  logic                push, handshake;

  // Ready and valid come from registered state only, so md_tx_ready never
  // reaches pop_ready combinationally.
  assign pop_ready   = (state != TWO);
  assign md_tx_valid = (state != EMPTY);
  assign push        = pop_valid & pop_ready;
  assign handshake   = md_tx_valid & md_tx_ready;

  assign md_tx_data   = head_q[ALGN_DATA_WIDTH-1:0];
  assign md_tx_offset = head_q[ALGN_DATA_WIDTH+OFFSET_W-1:ALGN_DATA_WIDTH];
  assign md_tx_size   = head_q[FIFO_W-1:ALGN_DATA_WIDTH+OFFSET_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      head_q <= head_nxt;
      skid_q <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    head_nxt  = head_q;
    skid_nxt  = skid_q;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt = ONE;
          head_nxt  = pop_data;
        end
      end
      ONE: begin
        if (push && handshake) begin
          head_nxt = pop_data;
        end else if (push) begin
          state_nxt = TWO;
          skid_nxt  = pop_data;
        end else if (handshake) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (handshake) begin
          state_nxt = ONE;
          head_nxt  = skid_q;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Stall detector: counts consecutive back-pressured cycles; stall_q lets the
  // pulse fire only on the rising edge of stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      stall_q   <= 1'b0;
    end else begin
      stall_q <= stall;
      if (!md_tx_valid || handshake)
        stall_cnt <= '0;
      else if (stall_cnt != STALL_MAX)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall       = (stall_cnt == STALL_MAX);
  assign stall_pulse = stall & ~stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tx_cnt <= '0;
    else if (clr_cnt)
      tx_cnt <= '0;
    else if (handshake && tx_cnt != CNT_MAX)
      tx_cnt <= tx_cnt + 1'b1;
  end

endmodule

// File: tb/tb_cfs_tx_ctrl_skid.sv
// Scoreboard bench for cfs_tx_ctrl_skid: a queue of accepted entries models the
// buffer; stall and counter behaviour are modelled cycle by cycle.
module tb_cfs_tx_ctrl_skid;

  localparam int DW       = 32;
  localparam int TH       = 4;
  localparam int CW       = 4;
  localparam int OFFSET_W = 2;
  localparam int SIZE_W   = 3;
  localparam int FIFO_W   = DW + OFFSET_W + SIZE_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              pop_valid = 1'b0;
  logic [FIFO_W-1:0] pop_data = '0;
  logic              pop_ready;
  logic              md_tx_valid;
  logic [DW-1:0]     md_tx_data;
  logic [OFFSET_W-1:0] md_tx_offset;
  logic [SIZE_W-1:0] md_tx_size;
  logic              md_tx_ready = 1'b0;
  logic              clr_cnt = 1'b0;
  logic [CW-1:0]     tx_cnt;
  logic              stall;
  logic              stall_pulse;

  int n_total = 0;
  int n_bad   = 0;
  int dut_pulses = 0;

  logic [FIFO_W-1:0] sb[$];
  int m_scnt = 0;
  bit m_stall_prev = 1'b0;
  int m_cnt = 0;

  cfs_tx_ctrl_skid #(
    .ALGN_DATA_WIDTH(DW),
    .STALL_THRESHOLD(TH),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pop_valid(pop_valid),
    .pop_data(pop_data),
    .pop_ready(pop_ready),
    .md_tx_valid(md_tx_valid),
    .md_tx_data(md_tx_data),
    .md_tx_offset(md_tx_offset),
    .md_tx_size(md_tx_size),
    .md_tx_ready(md_tx_ready),
    .clr_cnt(clr_cnt),
    .tx_cnt(tx_cnt),
    .stall(stall),
    .stall_pulse(stall_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (stall_pulse === 1'b1) dut_pulses++;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valid"}, 64'(md_tx_valid), 64'd0);
    checkOutput({tag, "_data"}, 64'(md_tx_data), 64'd0);
    checkOutput({tag, "_offset"}, 64'(md_tx_offset), 64'd0);
    checkOutput({tag, "_size"}, 64'(md_tx_size), 64'd0);
    checkOutput({tag, "_pop_ready"}, 64'(pop_ready), 64'd1);
    checkOutput({tag, "_tx_cnt"}, 64'(tx_cnt), 64'd0);
    checkOutput({tag, "_stall"}, 64'(stall), 64'd0);
    checkOutput({tag, "_pulse"}, 64'(stall_pulse), 64'd0);
  endtask

  task automatic resetModel();
    sb.delete();
    m_scnt = 0;
    m_stall_prev = 1'b0;
    m_cnt = 0;
  endtask

  // Drives one cycle of inputs, compares DUT outputs against the model at the
  // falling edge, then advances the model across the rising edge.
  task automatic applyStimulus(input logic pv, input logic [FIFO_W-1:0] pd,
                               input logic rdy, input logic clr);
    logic [FIFO_W-1:0] head_e;
    bit exp_valid, exp_ready, exp_stall, exp_pulse, hs, psh;
    pop_valid   = pv;
    pop_data    = pd;
    md_tx_ready = rdy;
    clr_cnt     = clr;
    @(negedge clk);
    exp_valid = (sb.size() != 0);
    exp_ready = (sb.size() < 2);
    exp_stall = (m_scnt == TH);
    exp_pulse = exp_stall && !m_stall_prev;
    checkOutput("pop_ready", 64'(pop_ready), 64'(exp_ready));
    checkOutput("tx_valid", 64'(md_tx_valid), 64'(exp_valid));
    if (exp_valid) begin
      head_e = sb[0];
      checkOutput("tx_data", 64'(md_tx_data), 64'(head_e[DW-1:0]));
      checkOutput("tx_offset", 64'(md_tx_offset), 64'(head_e[DW+OFFSET_W-1:DW]));
      checkOutput("tx_size", 64'(md_tx_size), 64'(head_e[FIFO_W-1:DW+OFFSET_W]));
    end
    checkOutput("stall", 64'(stall), 64'(exp_stall));
    checkOutput("stall_pulse", 64'(stall_pulse), 64'(exp_pulse));
    checkOutput("tx_cnt", 64'(tx_cnt), 64'(m_cnt));
    @(posedge clk);
    hs  = exp_valid && rdy;
    psh = pv && exp_ready;
    if (clr) m_cnt = 0;
    else if (hs && m_cnt != (1 << CW) - 1) m_cnt++;
    m_stall_prev = exp_stall;
    if (!exp_valid || hs) m_scnt = 0;
    else if (m_scnt < TH) m_scnt++;
    if (hs) void'(sb.pop_front());
    if (psh) sb.push_back(pd);
    #1;
  endtask

  function automatic logic [FIFO_W-1:0] mkEntry(input int sz, input int off, input logic [DW-1:0] d);
    return {SIZE_W'(sz), OFFSET_W'(off), d};
  endfunction

  initial begin
    int p0;
    #1 reset = 1'b1;
    #1 checkResetValues("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues("rst_held");
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single transfer");
    applyStimulus(1, mkEntry(2, 1, 32'hA5A5_A5A5), 1, 0);
    applyStimulus(0, '0, 1, 0);
    checkOutput("t037_cnt", 64'(tx_cnt), 64'd1);
    checkOutput("t037_empty", 64'(md_tx_valid), 64'd0);

    $display("[TB] back-pressure fill and drain");
    applyStimulus(0, '0, 0, 1);
    applyStimulus(1, mkEntry(1, 0, 32'h1111_0001), 0, 0);
    applyStimulus(1, mkEntry(2, 1, 32'h2222_0002), 0, 0);
    applyStimulus(1, mkEntry(3, 2, 32'h3333_0003), 0, 0);
    checkOutput("t038_full", 64'(pop_ready), 64'd0);
    repeat (3) applyStimulus(0, '0, 1, 0);
    checkOutput("t038_cnt", 64'(tx_cnt), 64'd2);
    checkOutput("t038_empty", 64'(md_tx_valid), 64'd0);

    $display("[TB] stall detection");
    applyStimulus(1, mkEntry(4, 3, 32'hDEAD_BEEF), 0, 0);
    p0 = dut_pulses;
    repeat (3) applyStimulus(0, '0, 0, 0);
    checkOutput("t039_stall_pre", 64'(stall), 64'd0);
    applyStimulus(0, '0, 0, 0);
    checkOutput("t039_stall_on", 64'(stall), 64'd1);
    repeat (2) applyStimulus(0, '0, 0, 0);
    checkOutput("t039_pulses", 64'(dut_pulses - p0), 64'd1);
    applyStimulus(0, '0, 1, 0);
    checkOutput("t039_stall_off", 64'(stall), 64'd0);

    $display("[TB] counter saturation and clear");
    applyStimulus(0, '0, 1, 1);
    for (int i = 0; i < 20; i++) applyStimulus(1, mkEntry(i % 8, i % 4, DW'(i)), 1, 0);
    repeat (2) applyStimulus(0, '0, 1, 0);
    checkOutput("t040_sat", 64'(tx_cnt), 64'd15);
    applyStimulus(1, mkEntry(1, 1, 32'h0F0F_0F0F), 1, 0);
    applyStimulus(0, '0, 1, 1);
    checkOutput("t040_clr", 64'(tx_cnt), 64'd0);

    $display("[TB] reset while full and stalled");
    applyStimulus(1, mkEntry(1, 1, 32'hAAAA_0001), 0, 0);
    applyStimulus(1, mkEntry(2, 2, 32'hAAAA_0002), 0, 0);
    repeat (4) applyStimulus(0, '0, 0, 0);
    checkOutput("t041_stall", 64'(stall), 64'd1);
    checkOutput("t041_full", 64'(pop_ready), 64'd0);
    p0 = dut_pulses;
    #2 reset = 1'b1;
    #1 checkResetValues("t041_async");
    resetModel();
    @(posedge clk);
    #1 checkResetValues("t041_held");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1, mkEntry(3, 0, 32'h5555_CCCC), 1, 0);
    applyStimulus(0, '0, 1, 0);
    applyStimulus(0, '0, 1, 0);
    checkOutput("t041_no_pulse", 64'(dut_pulses - p0), 64'd0);
    checkOutput("t041_cnt", 64'(tx_cnt), 64'd1);

    $display("[TB] random traffic");
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    {SIZE_W'($urandom), OFFSET_W'($urandom), DW'($urandom)},
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
